// File: rtl/calc_pkg.sv
// Shared calculator constants and the digit splitter state encoding.
package calc_pkg;

  localparam int RESULT_W = 32;
  localparam logic [3:0] ERR_DIGIT_DEFAULT = 4'hE;
  localparam int MAX_DISPLAY = 9999;
  localparam int BCD_ITER = 14;
  localparam int DIGITS = 4;
  localparam int MAG_W = 14;
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } state_t;

endpackage

// File: rtl/result_digit_splitter_if.sv
// Start/busy/done handshake plus result digits between the arithmetic step and the display.
interface result_digit_splitter_if #(
  parameter int IN_W = 32
);

  logic            start;
  logic [IN_W-1:0] value;
  logic            busy;
  logic            done;
  logic [3:0]      digit0;
  logic [3:0]      digit1;
  logic [3:0]      digit2;
  logic [3:0]      digit3;
  logic            negative;
  logic            overflow;

  modport master (
    output start, value,
    input  busy, done, digit0, digit1, digit2, digit3, negative, overflow
  );

  modport slave (
    input  start, value,
    output busy, done, digit0, digit1, digit2, digit3, negative, overflow
  );

endinterface

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD nibble: add 3 when the nibble is 5 or more.
module bcd_digit_adjust (
  input  logic [3:0] nibble,
  output logic [3:0] adjusted
);

  assign adjusted = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/result_digit_splitter.sv
// Iterative binary-to-BCD conversion of the signed calculator result into four display digits.
module result_digit_splitter
  import calc_pkg::*;
#(
  parameter int         IN_W      = RESULT_W,
  parameter logic [3:0] ERR_DIGIT = ERR_DIGIT_DEFAULT
) (
  input logic                     clk,
  input logic                     calculator_reset,
  result_digit_splitter_if.slave  bus
);

  localparam logic [3:0] ITER_LAST = 4'(BCD_ITER - 1);

  state_t           state;
  logic [IN_W-1:0]  mag;
  logic [MAG_W-1:0] shift_reg;
  logic [BCD_W-1:0] bcd;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_next;
  logic [3:0]       iter;
  logic             neg;

  // Negating the most negative value wraps back to 2^(IN_W-1), which still reads as too large.
  assign mag = bus.value[IN_W-1] ? (~bus.value) + {{(IN_W-1){1'b0}}, 1'b1} : bus.value;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adjust u_adj (
      .nibble   (bcd[4*i +: 4]),
      .adjusted (bcd_adj[4*i +: 4])
    );
  end

  assign bcd_next = {bcd_adj[BCD_W-2:0], shift_reg[MAG_W-1]};

  // NOTE: every register here, including the datapath, is reset so an aborted conversion leaves no residue.
  always_ff @(posedge clk or posedge calculator_reset) begin
    if (calculator_reset) begin
      state        <= IDLE;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.digit0   <= '0;
      bus.digit1   <= '0;
      bus.digit2   <= '0;
      bus.digit3   <= '0;
      bus.negative <= 1'b0;
      bus.overflow <= 1'b0;
      shift_reg    <= '0;
      bcd          <= '0;
      iter         <= '0;
      neg          <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register sees the pre-edge values.
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            neg      <= bus.value[IN_W-1];
            bus.busy <= 1'b1;
            if (mag > IN_W'(MAX_DISPLAY)) begin
              state        <= DONE;
              bus.done     <= 1'b1;
              bus.digit0   <= ERR_DIGIT;
              bus.digit1   <= ERR_DIGIT;
              bus.digit2   <= ERR_DIGIT;
              bus.digit3   <= ERR_DIGIT;
              bus.overflow <= 1'b1;
              bus.negative <= bus.value[IN_W-1];
            end else begin
              shift_reg <= mag[MAG_W-1:0];
              bcd       <= '0;
              iter      <= '0;
              state     <= CONVERT;
            end
          end
        end
        CONVERT: begin
          bcd       <= bcd_next;
          shift_reg <= {shift_reg[MAG_W-2:0], 1'b0};
          iter      <= iter + 4'd1;
          // Outputs are loaded on the final shift so they are already valid while done is high.
          if (iter == ITER_LAST) begin
            state        <= DONE;
            bus.done     <= 1'b1;
            bus.digit0   <= bcd_next[3:0];
            bus.digit1   <= bcd_next[7:4];
            bus.digit2   <= bcd_next[11:8];
            bus.digit3   <= bcd_next[15:12];
            bus.overflow <= 1'b0;
            bus.negative <= neg;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
